// File: rtl/drum_hit_detector.sv
// Drum hit detector: thresholds per-frame peak amplitude, holds off, re-arms with hysteresis.
// Define DRUM_BAND_CLASSIFY_EN to classify hits into kick/snare/hi-hat bands by frequency.
module drum_hit_detector #(
    parameter logic [9:0]  THRESH         = 10'd200,
    parameter logic [9:0]  HYST           = 10'd40,
    parameter logic [3:0]  HOLDOFF_FRAMES = 4'd6,
    parameter logic [12:0] BAND0_MAX      = 13'd300,
    parameter logic [12:0] BAND1_MAX      = 13'd1200
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        frame_end,
    input  logic [12:0] max_freq,
    input  logic [9:0]  max_amp,
    output logic        hit,
    output logic [1:0]  drum_id,
    output logic [12:0] hit_freq,
    output logic [9:0]  hit_amp,
    output logic        busy
);

    localparam logic [1:0] ARMED   = 2'd0;
    localparam logic [1:0] HOLDOFF = 2'd1;
    localparam logic [1:0] REARM   = 2'd2;

    // Saturate so an oversized hysteresis never wraps into a huge level.
    localparam logic [9:0] REARM_LVL = (HYST > THRESH) ? 10'd0 : (THRESH - HYST);

    logic [1:0] state;
    logic [3:0] count;
    logic       trig;

    assign trig = frame_end && (state == ARMED) && (max_amp >= THRESH);
    assign busy = (state != ARMED);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ARMED;
            count    <= 4'd0;
            hit      <= 1'b0;
            hit_freq <= 13'd0;
            hit_amp  <= 10'd0;
        end else begin
            hit <= trig;
            if (frame_end) begin
                unique case (state)
                    ARMED: begin
                        if (trig) begin
                            hit_freq <= max_freq;
                            hit_amp  <= max_amp;
                            count    <= HOLDOFF_FRAMES;
                            state    <= (HOLDOFF_FRAMES == 4'd0) ? REARM : HOLDOFF;
                        end
                    end
                    HOLDOFF: begin
                        count <= count - 4'd1;
                        if (count <= 4'd1) begin
                            state <= REARM;
                        end
                    end
                    REARM: begin
                        if (max_amp < REARM_LVL) begin
                            state <= ARMED;
                        end
                    end
                    default: state <= ARMED;
                endcase
            end
        end
    end

`ifdef DRUM_BAND_CLASSIFY_EN
    logic [1:0] band;

    always_comb begin
        band = 2'd2;
        if (max_freq <= BAND0_MAX) begin
            band = 2'd0;
        end else if (max_freq <= BAND1_MAX) begin
            band = 2'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drum_id <= 2'd0;
        end else if (trig) begin
            drum_id <= band;
        end
    end
`else
    assign drum_id = 2'd0;
`endif

endmodule

// File: tb/tb_drum_hit_detector.sv
// Scoreboard bench for drum_hit_detector: directed frames push expected hits,
// a negedge monitor pops and compares whenever hit is presented.
module tb_drum_hit_detector;

`ifdef DRUM_BAND_CLASSIFY_EN
    localparam bit CLS = 1'b1;
`else
    localparam bit CLS = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [1:0]  id;
        logic [12:0] freq;
        logic [9:0]  amp;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_end = 1'b0;
    logic [12:0] max_freq = 13'd0;
    logic [9:0]  max_amp = 10'd0;

    logic        hit, busy, hit1, busy1;
    logic [1:0]  drum_id, drum_id1;
    logic [12:0] hit_freq, hit_freq1;
    logic [9:0]  hit_amp, hit_amp1;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];

    drum_hit_detector u0 (
        .clock(clock), .reset_n(reset_n), .frame_end(frame_end),
        .max_freq(max_freq), .max_amp(max_amp), .hit(hit),
        .drum_id(drum_id), .hit_freq(hit_freq), .hit_amp(hit_amp), .busy(busy)
    );

    drum_hit_detector #(.HOLDOFF_FRAMES(4'd0)) u1 (
        .clock(clock), .reset_n(reset_n), .frame_end(frame_end),
        .max_freq(max_freq), .max_amp(max_amp), .hit(hit1),
        .drum_id(drum_id1), .hit_freq(hit_freq1), .hit_amp(hit_amp1), .busy(busy1)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per presented hit, flags missed ones.
    always @(negedge clock) begin
        if (q.size() != 0 && q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_hit: no hit at cycle %0d (now %0d)", q[0].cyc, cyc);
            void'(q.pop_front());
        end
        if (reset_n && hit) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_hit: hit=1 at cycle %0d, none expected", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("hit_cycle", cyc, e.cyc);
                chk("drum_id", {30'd0, drum_id}, {30'd0, e.id});
                chk("hit_freq", {19'd0, hit_freq}, {19'd0, e.freq});
                chk("hit_amp", {22'd0, hit_amp}, {22'd0, e.amp});
            end
        end
    end

    // One frame_end cycle; leaves time at posedge+1 with frame_end low.
    task automatic frame(input int amp, input int freq, input bit exp_hit, input logic [1:0] id);
        exp_t e;
        max_amp   = amp[9:0];
        max_freq  = freq[12:0];
        frame_end = 1'b1;
        if (exp_hit) begin
            e.cyc  = cyc + 1;
            e.id   = CLS ? id : 2'd0;
            e.freq = freq[12:0];
            e.amp  = amp[9:0];
            q.push_back(e);
        end
        @(posedge clock);
        #1;
        frame_end = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Six holdoff frames then a quiet frame back to ARMED.
    task automatic recover();
        repeat (6) frame(300, 50, 1'b0, 2'd0);
        chk("busy_in_rearm", {31'd0, busy}, 32'd1);
        frame(0, 0, 1'b0, 2'd0);
        chk("busy_rearmed", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        idle(2);
        chk("rst_hit", {31'd0, hit}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_id", {30'd0, drum_id}, 32'd0);
        chk("rst_freq", {19'd0, hit_freq}, 32'd0);
        chk("rst_amp", {22'd0, hit_amp}, 32'd0);
        reset_n = 1'b1;
        idle(1);

        // Large amplitude without frame_end must be ignored.
        max_amp = 10'd500;
        max_freq = 13'd700;
        idle(5);
        chk("no_frame_busy", {31'd0, busy}, 32'd0);

        frame(250, 150, 1'b1, 2'd0);
        chk("busy_after_trig", {31'd0, busy}, 32'd1);

        // Back-to-back: first one lands while hit is high.
        repeat (6) frame(300, 900, 1'b0, 2'd0);
        chk("busy_after_holdoff", {31'd0, busy}, 32'd1);
        frame(100, 900, 1'b0, 2'd0);
        chk("busy_rearm_100", {31'd0, busy}, 32'd0);
        frame(199, 900, 1'b0, 2'd0);
        frame(250, 900, 1'b1, 2'd1);
        idle(1);

        repeat (6) frame(0, 0, 1'b0, 2'd0);
        frame(170, 0, 1'b0, 2'd0);
        chk("rearm_170", {31'd0, busy}, 32'd1);
        frame(160, 0, 1'b0, 2'd0);
        chk("rearm_160", {31'd0, busy}, 32'd1);
        frame(159, 0, 1'b0, 2'd0);
        chk("rearm_159", {31'd0, busy}, 32'd0);
        frame(200, 3000, 1'b1, 2'd2);
        recover();

        frame(250, 300, 1'b1, 2'd0);
        recover();
        frame(250, 301, 1'b1, 2'd1);
        recover();
        frame(250, 1200, 1'b1, 2'd1);
        recover();
        frame(250, 1201, 1'b1, 2'd2);
        idle(1);

        // Asynchronous reset mid-holdoff.
        frame(0, 0, 1'b0, 2'd0);
        frame(0, 0, 1'b0, 2'd0);
        chk("busy_mid_holdoff", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #2;
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_amp", {22'd0, hit_amp}, 32'd0);
        chk("async_freq", {19'd0, hit_freq}, 32'd0);
        chk("async_id", {30'd0, drum_id}, 32'd0);
        idle(1);
        reset_n = 1'b1;
        idle(1);
        frame(200, 2000, 1'b1, 2'd2);
        idle(1);

        // Zero holdoff instance: trigger goes straight to REARM.
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        idle(1);
        frame(250, 150, 1'b1, 2'd0);
        chk("u1_hit", {31'd0, hit1}, 32'd1);
        chk("u1_busy_rearm", {31'd0, busy1}, 32'd1);
        frame(300, 150, 1'b0, 2'd0);
        chk("u1_no_rehit", {31'd0, hit1}, 32'd0);
        chk("u1_stay_rearm", {31'd0, busy1}, 32'd1);
        frame(100, 150, 1'b0, 2'd0);
        chk("u1_armed", {31'd0, busy1}, 32'd0);

        idle(3);
        chk("queue_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/drum_hit_detector.md
DRUM_HIT_DETECTOR -- requirements
Module: drum_hit_detector

Interface
REQ-001 SHALL have parameter THRESH, default 10'd200, minimum max_amp that triggers a hit.
REQ-002 SHALL have parameter HYST, default 10'd40, re-arm hysteresis below THRESH.
REQ-003 SHALL have parameter HOLDOFF_FRAMES, default 4'd6, frames ignored after a hit.
REQ-004 SHALL have parameter BAND0_MAX, default 13'd300, inclusive upper frequency of band 0 (kick).
REQ-005 SHALL have parameter BAND1_MAX, default 13'd1200, inclusive upper frequency of band 1 (snare).
REQ-006 SHALL have port clock  input  1  single system clock; all state changes on its rising edge.
REQ-007 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port frame_end  input  1  one-cycle pulse marking the last column of a spectrum frame.
REQ-009 SHALL have port max_freq  input  13  frame peak frequency from the upstream peak search.
REQ-010 SHALL have port max_amp  input  10  frame peak amplitude from the upstream peak search.
REQ-011 SHALL have port hit  output  1  one-cycle registered hit pulse.
REQ-012 SHALL have port drum_id  output  2  band of the last hit: 0 kick, 1 snare, 2 hi-hat.
REQ-013 SHALL have port hit_freq  output  13  max_freq captured at the last hit.
REQ-014 SHALL have port hit_amp  output  10  max_amp captured at the last hit.
REQ-015 SHALL have port busy  output  1  high whenever the FSM is not in ARMED.

Function
REQ-016 SHALL sample max_freq and max_amp only in cycles where frame_end is 1; inputs SHALL be ignored otherwise.
REQ-017 SHALL implement an FSM with states ARMED, HOLDOFF and REARM.
REQ-018 ARMED: frame_end with max_amp >= THRESH SHALL capture hit_freq, hit_amp and drum_id, pulse hit on the next cycle, load counter = HOLDOFF_FRAMES, and enter HOLDOFF (or REARM if HOLDOFF_FRAMES = 0).
REQ-019 Hit latency SHALL be exactly 1 cycle: hit is high in the cycle after the triggering frame_end, for one cycle only.
REQ-020 HOLDOFF: each frame_end SHALL decrement the counter; on the frame_end that brings it to 0 the FSM SHALL enter REARM.
REQ-021 REARM: frame_end with max_amp < re-arm level SHALL enter ARMED; otherwise the FSM SHALL stay in REARM.
REQ-022 The re-arm level SHALL be THRESH - HYST, saturating at 0 when HYST > THRESH (then REARM never exits except by reset).
REQ-023 Band classification: max_freq <= BAND0_MAX -> 0; else max_freq <= BAND1_MAX -> 1; else 2 (boundaries inclusive).
REQ-024 hit_freq, hit_amp and drum_id SHALL hold their values until the next hit.
REQ-025 A frame_end in the cycle immediately after a trigger (hit high) SHALL count as a HOLDOFF frame.
REQ-026 Amplitude compares SHALL be unsigned 10-bit; there SHALL be no arithmetic overflow on the re-arm level.

Reset
REQ-027 reset_n low SHALL immediately force state ARMED, counter 0, hit 0, drum_id 0, hit_freq 0, hit_amp 0 and busy 0.
REQ-028 Reset asserted mid-HOLDOFF SHALL abort the holdoff, and the first frame_end after release SHALL be evaluated in ARMED.

Configuration
REQ-029 Macro DRUM_BAND_CLASSIFY_EN defined: drum_id SHALL follow REQ-023.
REQ-030 Macro DRUM_BAND_CLASSIFY_EN undefined: drum_id SHALL be constant 0, no band comparators SHALL be built, and all other behaviour SHALL be unchanged.

Verification
REQ-031 Reset, then frame_end with amp=250, freq=150 -> hit high for 1 cycle next clock; drum_id=0, hit_amp=250, hit_freq=150, busy=1.
REQ-032 After a trigger, 6 frame_ends at amp=300 -> no hit; 7th frame_end at amp=100 -> ARMED, busy=0; 8th at amp=250, freq=900 -> hit with drum_id=1.
REQ-033 In REARM, frame_ends at amp=170 -> stays REARM; amp=159 -> ARMED; the next frame_end at amp=200, freq=3000 -> hit, drum_id=2.
REQ-034 Band edges: triggers at freq=300, 301, 1200 and 1201 -> drum_id 0, 1, 1 and 2 respectively (with macro); all 0 without macro.
REQ-035 reset_n pulsed low during HOLDOFF -> outputs cleared asynchronously; first frame_end after release at amp=200 -> hit.
REQ-036 max_amp=500 held with frame_end=0 -> no hit; HOLDOFF_FRAMES=0, trigger -> REARM on the next cycle.
